// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_packer
//  Description : Read-side consumer of an async FIFO (rd_clk domain). Pops
//                narrow words, packs RATIO of them into one wide word and
//                presents it on a valid/ready stream. A flush request emits
//                a partial group with its word count. One group assembles in
//                the pack register while the previous one waits on out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
    parameter int DATA_W = 8,
    parameter int RATIO  = 4,
    parameter int CNT_W  = $clog2(RATIO + 1)
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic                      fifo_empty,
    output logic                      fifo_pop,
    input  logic [DATA_W-1:0]         fifo_rdata,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W*RATIO-1:0]   out_data,
    output logic [CNT_W-1:0]          out_cnt,
    output logic                      busy
);

    localparam int PACK_W = DATA_W * RATIO;

    localparam logic [1:0] c_ST_FILL  = 2'd0;
    localparam logic [1:0] c_ST_FULL  = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    localparam logic [CNT_W-1:0] c_RATIO_CNT = CNT_W'(RATIO);
    localparam logic [CNT_W-1:0] c_LAST_CNT  = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] c_ONE_CNT   = CNT_W'(1);

    // Registered state
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;        // words already landed in the pack register
    logic              r_rd_pend;    // pop issued last cycle, its data lands now
    logic              r_flush_req;
    logic [PACK_W-1:0] r_pack;
    logic              r_out_valid;
    logic [PACK_W-1:0] r_out_data;
    logic [CNT_W-1:0]  r_out_cnt;

    // Next-state values
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_flush_req_nxt;
    logic [PACK_W-1:0] w_pack_nxt;
    logic              w_out_valid_nxt;
    logic [PACK_W-1:0] w_out_data_nxt;
    logic [CNT_W-1:0]  w_out_cnt_nxt;

    // Helpers
    logic              w_slot_free;
    logic [CNT_W-1:0]  w_inflight;
    logic              w_pop;
    logic [CNT_W-1:0]  w_cnt_landed;
    logic [PACK_W-1:0] w_pack_landed;
    logic              w_group_done;

    // The output slot can take a new word if empty or being drained this edge.
    assign w_slot_free = !r_out_valid || out_ready;

    // Words landed plus the one still in flight; pops stop once a group is claimed.
    assign w_inflight = r_cnt + (r_rd_pend ? c_ONE_CNT : '0);

    // Reset gates the strobe so nothing is taken from the FIFO while held in reset.
    assign w_pop = rd_rst && (r_state == c_ST_FILL) && !fifo_empty &&
                   (w_inflight < c_RATIO_CNT) && !r_flush_req;

    assign w_cnt_landed = r_rd_pend ? (r_cnt + c_ONE_CNT) : r_cnt;
    assign w_group_done = r_rd_pend && (r_cnt == c_LAST_CNT);

    // Pack register image with the in-flight word written to lane r_cnt.
    always_comb begin
        w_pack_landed = r_pack;
        for (int k = 0; k < RATIO; k++) begin
            if (r_rd_pend && (r_cnt == CNT_W'(k))) begin
                w_pack_landed[k*DATA_W +: DATA_W] = fifo_rdata;
            end
        end
    end

    // Next-state and output-register logic for the FILL/FULL/FLUSH machine.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = w_cnt_landed;
        w_pack_nxt      = w_pack_landed;
        w_flush_req_nxt = r_flush_req || flush;
        w_out_valid_nxt = r_out_valid && !out_ready;
        w_out_data_nxt  = r_out_data;
        w_out_cnt_nxt   = r_out_cnt;

        case (r_state)
            c_ST_FILL: begin
                if (w_group_done && w_slot_free) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = w_pack_landed;
                    w_out_cnt_nxt   = c_RATIO_CNT;
                    w_cnt_nxt       = '0;
                    w_pack_nxt      = '0;
                    if (r_flush_req) begin
                        w_state_nxt = c_ST_FLUSH;
                    end
                end else if (w_group_done) begin
                    // Completed group parks here until the output slot frees up.
                    w_state_nxt = c_ST_FULL;
                end else if (r_flush_req) begin
                    w_state_nxt = c_ST_FLUSH;
                end
            end

            c_ST_FULL: begin
                if (w_slot_free) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = r_pack;
                    w_out_cnt_nxt   = c_RATIO_CNT;
                    w_cnt_nxt       = '0;
                    w_pack_nxt      = '0;
                    w_state_nxt     = r_flush_req ? c_ST_FLUSH : c_ST_FILL;
                end
            end

            c_ST_FLUSH: begin
                // An in-flight word still lands (defaults) before the flush resolves.
                if (!r_rd_pend) begin
                    if (r_cnt == '0) begin
                        w_flush_req_nxt = 1'b0;
                        w_state_nxt     = c_ST_FILL;
                    end else if (w_slot_free) begin
                        w_out_valid_nxt = 1'b1;
                        w_out_data_nxt  = r_pack;
                        w_out_cnt_nxt   = r_cnt;
                        w_cnt_nxt       = '0;
                        w_pack_nxt      = '0;
                        w_flush_req_nxt = 1'b0;
                        w_state_nxt     = c_ST_FILL;
                    end
                end
            end

            default: begin
                w_state_nxt = c_ST_FILL;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst) begin
            r_state     <= c_ST_FILL;
            r_cnt       <= '0;
            r_rd_pend   <= 1'b0;
            r_flush_req <= 1'b0;
            r_pack      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rd_pend   <= w_pop;
            r_flush_req <= w_flush_req_nxt;
            r_pack      <= w_pack_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
        end
    end

    assign fifo_pop  = w_pop;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_cnt   = r_out_cnt;
    assign busy      = (r_state != c_ST_FILL) || (r_cnt != '0) || r_rd_pend || r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_packer
//  Description : Self-checking bench for fifo_rd_packer. A queue models the
//                FIFO, a group/flush model predicts output beats, and directed
//                scenarios pin the model with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;

    localparam int DATA_W = 8;
    localparam int RATIO  = 4;
    localparam int CNT_W  = 3;

    logic              rd_clk = 1'b0;
    logic              rd_rst = 1'b0;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rdata = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_data;
    logic [CNT_W-1:0]  out_cnt;
    logic              busy;

    fifo_rd_packer #(.DATA_W(DATA_W), .RATIO(RATIO), .CNT_W(CNT_W)) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_rdata (fifo_rdata),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_cnt    (out_cnt),
        .busy       (busy)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct {
        logic [31:0]      data;
        logic [CNT_W-1:0] cnt;
    } beat_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    logic [7:0]  fifo_q[$];
    int          q_count = 0;
    logic        pop_seen = 1'b0;

    logic [7:0]  pend[$];
    beat_t       exp_q[$];
    logic [31:0] log_data[$];
    logic [CNT_W-1:0] log_cnt[$];
    int          log_cyc[$];
    int          pop_log[$];

    logic        stall_prev = 1'b0;
    logic [31:0] prev_data = '0;
    logic [CNT_W-1:0] prev_cnt = '0;

    assign fifo_empty = (q_count == 0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] w);
        fifo_q.push_back(w);
        q_count = fifo_q.size();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge rd_clk);
        #3;
    endtask

    function automatic beat_t make_beat();
        beat_t b;
        b.data = '0;
        for (int i = 0; i < pend.size(); i++) b.data[i*8 +: 8] = pend[i];
        b.cnt = CNT_W'(pend.size());
        return b;
    endfunction

    // FIFO model: the popped word appears on fifo_rdata one cycle after the pop.
    always @(posedge rd_clk) begin
        #2;
        if (pop_seen && fifo_q.size() > 0) begin
            fifo_rdata = fifo_q.pop_front();
        end else begin
            fifo_rdata = 8'($urandom);
        end
        q_count = fifo_q.size();
    end

    // Reference model and compare process, sampled mid-cycle.
    always @(negedge rd_clk) begin
        cyc++;
        pop_seen = fifo_pop;
        if (!rd_rst) begin
            pend.delete();
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (fifo_pop) begin
                chk("pop_while_empty", {63'd0, fifo_empty}, 64'd0);
                pop_log.push_back(cyc);
                if (fifo_q.size() > 0) pend.push_back(fifo_q[0]);
            end
            if (pend.size() == RATIO) begin
                exp_q.push_back(make_beat());
                pend.delete();
            end
            if (flush && pend.size() > 0) begin
                exp_q.push_back(make_beat());
                pend.delete();
            end
            if (stall_prev) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_data", {32'd0, out_data}, {32'd0, prev_data});
                chk("hold_cnt", {61'd0, out_cnt}, {61'd0, prev_cnt});
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_beat: got data %h cnt %0d expected none", out_data, out_cnt);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_cnt !== e.cnt) begin
                        n_errors++;
                        $display("FAIL beat_compare: got %h/%0d expected %h/%0d (cycle %0d)",
                                 out_data, out_cnt, e.data, e.cnt, cyc);
                    end
                end
                log_data.push_back(out_data);
                log_cnt.push_back(out_cnt);
                log_cyc.push_back(cyc);
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_cnt   = out_cnt;
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (q_count == 0 && !busy && !fifo_pop && exp_q.size() == 0) break;
            step(1);
        end
        chk({name, "_idle_timeout"}, {63'd0, (i >= budget)}, 64'd0);
    endtask

    task automatic check_beat(input string name, input int idx,
                              input logic [31:0] d, input logic [CNT_W-1:0] c);
        if (idx >= log_data.size()) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no beat at index %0d expected %h/%0d", name, idx, d, c);
        end else begin
            chk({name, "_data"}, {32'd0, log_data[idx]}, {32'd0, d});
            chk({name, "_cnt"}, {61'd0, log_cnt[idx]}, {61'd0, c});
        end
    endtask

    initial begin
        int pb;
        int lb;
        // 1: reset with data available
        rd_rst = 1'b0;
        push(8'h99);
        step(2);
        chk("rst_pop", {63'd0, fifo_pop}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        fifo_q.delete();
        q_count = 0;
        step(1);
        rd_rst = 1'b1;
        step(1);

        // 2: two full groups at full rate
        out_ready = 1'b1;
        pb = pop_log.size();
        lb = log_data.size();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        wait_idle("t2", 60);
        chk("t2_pops", 64'(pop_log.size() - pb), 64'd8);
        chk("t2_beats", 64'(log_data.size() - lb), 64'd2);
        check_beat("t2_beat0", lb, 32'h44332211, 3'd4);
        check_beat("t2_beat1", lb + 1, 32'h88776655, 3'd4);
        if (pop_log.size() >= pb + 8 && log_cyc.size() >= lb + 2) begin
            chk("t2_latency", 64'(log_cyc[lb] - pop_log[pb+3]), 64'd2);
            chk("t2_total", 64'(log_cyc[lb+1] - pop_log[pb]), 64'd10);
        end

        // 3: backpressure with 12 words queued
        out_ready = 1'b0;
        pb = pop_log.size();
        lb = log_data.size();
        for (int i = 1; i <= 12; i++) push(8'(i));
        step(20);
        chk("t3_pops_stalled", 64'(pop_log.size() - pb), 64'd8);
        chk("t3_held_valid", {63'd0, out_valid}, 64'd1);
        chk("t3_held_data", {32'd0, out_data}, 64'h04030201);
        chk("t3_busy", {63'd0, busy}, 64'd1);
        out_ready = 1'b1;
        wait_idle("t3", 60);
        check_beat("t3_beat1", lb, 32'h04030201, 3'd4);
        check_beat("t3_beat2", lb + 1, 32'h08070605, 3'd4);
        check_beat("t3_beat3", lb + 2, 32'h0C0B0A09, 3'd4);

        // 4: flush of a partial group, then flush while idle
        lb = log_data.size();
        push(8'hAA); push(8'hBB);
        step(4);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        wait_idle("t4a", 30);
        check_beat("t4_partial", lb, 32'h0000BBAA, 3'd2);
        lb = log_data.size();
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(2);
        chk("t4_idle_busy", {63'd0, busy}, 64'd0);
        chk("t4_idle_valid", {63'd0, out_valid}, 64'd0);
        chk("t4_idle_nobeat", 64'(log_data.size() - lb), 64'd0);

        // 5: flush in the same cycle as a pop
        lb = log_data.size();
        push(8'hCC);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        wait_idle("t5", 30);
        check_beat("t5_inflight", lb, 32'h000000CC, 3'd1);

        // 6: reset with a partial group landed
        push(8'h31); push(8'h32); push(8'h33);
        step(6);
        rd_rst = 1'b0;
        step(2);
        chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        rd_rst = 1'b1;
        step(1);
        lb = log_data.size();
        push(8'h41); push(8'h42); push(8'h43); push(8'h44);
        wait_idle("t6", 40);
        check_beat("t6_fresh", lb, 32'h44434241, 3'd4);
        chk("t6_beats", 64'(log_data.size() - lb), 64'd1);

        chk("model_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
